// File: rtl/char_feature_recognize.sv
// char_feature_recognize: counts stroke crossings on four probe lines inside
// a fixed character box and decodes one digit per frame from a code table.
// Ports:
//   clk, rst_n          pixel clock, async active-low reset
//   x, y                current pixel coordinates
//   i_vs, i_de, i_data  vsync, data enable, binarized pixel ([7:0] used)
//   reco_digital        last decoded digit, 4'hF when no table entry matched
//   reco_valid          one-cycle pulse when reco_digital updates
//   reco_hit            last decode matched a table entry
//   feature_code        last latched code {V1,V2,H1,H2}
module char_feature_recognize #(
  parameter int          POST_LEFT  = 70,
  parameter int          POST_UP    = 80,
  parameter int          BOX_W      = 70,
  parameter int          BOX_H      = 110,
  parameter int          COL1       = 23,
  parameter int          COL2       = 46,
  parameter int          ROW1       = 35,
  parameter int          ROW2       = 70,
  parameter logic [7:0]  THRESH     = 8'd128,
  parameter logic [79:0] CODE_TABLE = 80'hB9FA55E6E559F5B505AA
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] x,
  input  logic [11:0] y,
  input  logic        i_vs,
  input  logic        i_de,
  input  logic [23:0] i_data,
  output logic [3:0]  reco_digital,
  output logic        reco_valid,
  output logic        reco_hit,
  output logic [7:0]  feature_code
);

  localparam logic [11:0] X_LO = 12'(POST_LEFT);
  localparam logic [11:0] X_HI = 12'(POST_LEFT + BOX_W);
  localparam logic [11:0] Y_LO = 12'(POST_UP);
  localparam logic [11:0] Y_HI = 12'(POST_UP + BOX_H);
  localparam logic [11:0] X_C1 = 12'(POST_LEFT + COL1);
  localparam logic [11:0] X_C2 = 12'(POST_LEFT + COL2);
  localparam logic [11:0] Y_R1 = 12'(POST_UP + ROW1);
  localparam logic [11:0] Y_R2 = 12'(POST_UP + ROW2);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    DECODE = 2'd2
  } state_t;

  state_t state, state_n;

  logic       vs_d;
  logic       vs_rise;
  logic       in_box;
  logic       fg;
  logic       on_row1, on_row2;
  logic       on_col1, on_col2;
  logic       hp, vp1, vp2;
  logic       hp_eff, vp1_eff, vp2_eff;
  logic [1:0] h1, h2, v1, v2;
  logic [3:0] match_idx;
  logic       match_hit;
  logic       unused_hi;

  assign unused_hi = ^i_data[23:8];

  assign vs_rise = i_vs & ~vs_d;

  assign in_box = i_de
                & (x >= X_LO) & (x <= X_HI)
                & (y >= Y_LO) & (y <= Y_HI);
  assign fg     = in_box & (i_data[7:0] < THRESH);

  assign on_row1 = (y == Y_R1);
  assign on_row2 = (y == Y_R2);
  assign on_col1 = (x == X_C1);
  assign on_col2 = (x == X_C2);

  // Prev bits read as 0 on the cycle they are reset, so a stroke that
  // touches the box edge still counts on that first pixel.
  assign hp_eff  = (x == X_LO) ? 1'b0 : hp;
  assign vp1_eff = (y == Y_LO) ? 1'b0 : vp1;
  assign vp2_eff = (y == Y_LO) ? 1'b0 : vp2;

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == 2'd3) ? 2'd3 : c + 2'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_d  <= 1'b0;
      state <= IDLE;
    end else begin
      vs_d  <= i_vs;
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (vs_rise) state_n = ACCUM;
      ACCUM:   if (vs_rise) state_n = DECODE;
      DECODE:  state_n = ACCUM;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h1  <= '0;
      h2  <= '0;
      v1  <= '0;
      v2  <= '0;
      hp  <= 1'b0;
      vp1 <= 1'b0;
      vp2 <= 1'b0;
    end else if (state != ACCUM || vs_rise) begin
      h1  <= '0;
      h2  <= '0;
      v1  <= '0;
      v2  <= '0;
      hp  <= 1'b0;
      vp1 <= 1'b0;
      vp2 <= 1'b0;
    end else begin
      if (on_row1 && fg && !hp_eff) h1 <= sat_inc(h1);
      if (on_row2 && fg && !hp_eff) h2 <= sat_inc(h2);
      if ((on_row1 || on_row2) && in_box) hp <= fg;
      else if (x == X_LO)                 hp <= 1'b0;

      if (on_col1 && fg && !vp1_eff) v1 <= sat_inc(v1);
      if (on_col1 && in_box)         vp1 <= fg;
      else if (y == Y_LO)            vp1 <= 1'b0;

      if (on_col2 && fg && !vp2_eff) v2 <= sat_inc(v2);
      if (on_col2 && in_box)         vp2 <= fg;
      else if (y == Y_LO)            vp2 <= 1'b0;
    end
  end

  // Scan from the top entry down so the lowest matching index wins.
  always_comb begin
    match_hit = 1'b0;
    match_idx = 4'hF;
    for (int d = 9; d >= 0; d--) begin
      if (feature_code == CODE_TABLE[8*d +: 8]) begin
        match_hit = 1'b1;
        match_idx = 4'(d);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      feature_code <= 8'h00;
      reco_digital <= 4'hF;
      reco_hit     <= 1'b0;
      reco_valid   <= 1'b0;
    end else begin
      reco_valid <= (state == DECODE);
      if (state == ACCUM && vs_rise)
        feature_code <= {v1, v2, h1, h2};
      if (state == DECODE) begin
        reco_digital <= match_idx;
        reco_hit     <= match_hit;
      end
    end
  end

endmodule

// File: doc/char_feature_recognize.md
# char_feature_recognize

- Scans the binarized camera video ahead of the character overlay and recognizes one decimal digit per frame inside a fixed character box.
- Counts stroke crossings on two vertical and two horizontal probe lines and packs them into an 8-bit feature code.
- Matches the code against a 10-entry table at frame end and drives `reco_digital` into the overlay.

## Interface
- `POST_LEFT`, 70: left x of the character box.
- `POST_UP`, 80: top y of the character box.
- `BOX_W`, 70: box spans x in [POST_LEFT, POST_LEFT+BOX_W].
- `BOX_H`, 110: box spans y in [POST_UP, POST_UP+BOX_H].
- `COL1`, 23: x offset of vertical probe line 1.
- `COL2`, 46: x offset of vertical probe line 2.
- `ROW1`, 35: y offset of horizontal probe line 1.
- `ROW2`, 70: y offset of horizontal probe line 2.
- `THRESH`, 8'd128: a pixel is foreground when i_data[7:0] < THRESH.
- `CODE_TABLE`, 80'hB9FA55E6E559F5B505AA: entry d = bits [8d+7:8d] is the code for digit d.
- `clk` in 1: pixel clock, single clock domain.
- `rst_n` in 1: asynchronous, active-low reset.
- `x` in 12: current pixel x.
- `y` in 12: current pixel y.
- `i_vs` in 1: vertical sync, active high.
- `i_de` in 1: data enable.
- `i_data` in 24: binarized pixel; only [7:0] is used.
- `reco_digital` out 4: last recognized digit 0-9, or 4'hF if no match.
- `reco_valid` out 1: one-cycle pulse when reco_digital updates.
- `reco_hit` out 1: 1 if the last decode matched a table entry.
- `feature_code` out 8: last latched code {V1,V2,H1,H2}, 2 bits each.

## Operation
- Probe lines:
  - Vertical probe k is the column x == POST_LEFT+COLk.
  - Horizontal probe k is the row y == POST_UP+ROWk.
- in_box = i_de and x and y inside the box limits (inclusive).
- fg = in_box and (i_data[7:0] < THRESH). Pixels outside the box are treated as background.
- Horizontal counters H1/H2 (2-bit, saturate at 3):
  - Row prev bit hp is reset to 0 when x == POST_LEFT.
  - On a probe row, when in_box: fg and !hp increments Hk; then hp <= fg.
- Vertical counters V1/V2 (2-bit, saturate at 3):
  - Per-probe prev bits vp1 and vp2 are reset to 0 on row y == POST_UP.
  - At the probe column, when in_box: fg and !vpk increments Vk; then vpk <= fg.
  - A stroke crossing the probe line counts once, on its top edge.
- vs_rise = i_vs and not vs_d (vs_d is a registered copy of i_vs).
- FSM states:
  - IDLE (after reset): counters held at 0. On vs_rise go to ACCUM with no output, so the first partial frame is discarded.
  - ACCUM: counters update as above. On vs_rise: feature_code <= {V1,V2,H1,H2}, clear all counters and prev bits, go to DECODE. A pixel arriving in that same cycle is ignored.
  - DECODE (one cycle):
    - Compare feature_code against entries 0..9; the lowest matching index wins.
    - On match: reco_digital <= index, reco_hit <= 1.
    - Otherwise: reco_digital <= 4'hF, reco_hit <= 0.
    - reco_valid <= 1, then go to ACCUM.
- reco_digital, reco_hit and feature_code hold their values between decodes.
- reco_valid is 0 in every cycle except the one after DECODE.

## Timing
- Reset values:
  - reco_digital = 4'hF.
  - reco_valid = 0, reco_hit = 0, feature_code = 8'h00.
  - All counters and prev bits = 0; state = IDLE; vs_d = 0.
- Latency:
  - Edge E0 samples i_vs = 1 with vs_d = 0 and latches feature_code.
  - Edge E1 registers reco_digital, reco_hit and reco_valid = 1.
  - Edge E2 clears reco_valid.
- i_vs held high for many cycles produces exactly one vs_rise.
- rst_n asserted mid-frame or mid-DECODE:
  - All state clears immediately; no reco_valid pulse.
  - The FSM returns to IDLE and waits a full frame before the next result.
- Counter saturation: a fourth crossing on a probe leaves its count at 3.

## Test plan
- Reset, then drive two frames of all-background video -> first vs_rise gives no pulse; second gives feature_code = 00, reco_digital = F, reco_hit = 0, and a single reco_valid two edges after the i_vs rise.
- Frame with a 6-px-wide ring (digit 0) crossing all four probes twice -> feature_code = AA, reco_digital = 0, reco_hit = 1.
- Frame with a single vertical bar at x = POST_LEFT+35 spanning the box -> feature_code = 05, reco_digital = 1.
- Frame with four horizontal bars crossing probe column 1 -> V1 saturates at 3; code not in table -> reco_digital = F, reco_hit = 0.
- Foreground pixel at x = POST_LEFT-1 on probe row, and i_de low over a foreground pixel on a probe -> neither counts; feature_code unchanged from the baseline frame.
- Assert rst_n low for 1 cycle during ACCUM, with a valid digit-1 frame in progress -> outputs return to reset values; no pulse at that frame's vs_rise; next full digit-1 frame gives reco_digital = 1.
